// File: rtl/byte_to_smp_pkg.sv
// Shared ILA packing arithmetic (bytes per word, counter width, padding) and
// the byte-assembler FSM state encoding.
package byte_to_smp_pkg;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  function automatic int bytes_per_word(input int width);
    return ((width - 1) / 8) + 1;
  endfunction

  function automatic int cnt_width(input int width);
    int c;
    c = $clog2(bytes_per_word(width));
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int pad_bits(input int width);
    return bytes_per_word(width) * 8 - width;
  endfunction

endpackage

// File: rtl/word_hold_stage.sv
// One-word output holding register with valid/ready handshake and a sticky
// overflow flag that is released by the next frame-inactive cycle.
module word_hold_stage #(
  parameter int width = 24
) (
  input  logic             i_clk_ILA,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [width-1:0] i_data,
  input  logic             i_frame_active,
  input  logic             i_ready,
  output logic [width-1:0] o_word,
  output logic             o_valid,
  output logic             o_overflow
);

  // Handshake: a word transfers on any rising edge where o_valid && i_ready;
  // o_word never changes while o_valid=1 and i_ready=0, and a load arriving in
  // that state is dropped and flagged instead.
  logic drop;
  assign drop = i_load & o_valid & ~i_ready;

  always_ff @(posedge i_clk_ILA or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_word     <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (i_load) begin
        if (!o_valid || i_ready) begin
          o_word  <= i_data;
          o_valid <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      // A new drop beats the frame-end release in the same cycle.
      if (drop) begin
        o_overflow <= 1'b1;
      end else if (!i_frame_active) begin
        o_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/byte_to_smp.sv
// Reassembles a received byte stream (LSB byte first) into word_width-bit words
// and hands them to a one-word valid/ready holding stage.
module byte_to_smp
  import byte_to_smp_pkg::*;
#(
  parameter int word_width = 24
) (
  input  logic                  i_clk_ILA,
  input  logic                  i_rst_n,
  input  logic                  i_frame_active,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic [word_width-1:0] o_word,
  output logic                  o_word_valid,
  input  logic                  i_word_ready,
  output logic                  o_overflow,
  output logic                  o_busy
);

  localparam int BPW = bytes_per_word(word_width);
  localparam int CW  = cnt_width(word_width);
  localparam int CLW = BPW * 8;
  localparam logic [CW-1:0] LAST_CNT = CW'(BPW - 1);

  state_t          state;
  logic [CW-1:0]   byte_cnt;
  logic [CLW-1:0]  collect_q;
  logic [CLW-1:0]  collect_d;
  logic            byte_acc;
  logic            word_done;

  // New byte enters at the top; after the last byte the first one sits in [7:0].
  assign collect_d = CLW'({i_byte, collect_q} >> 8);
  assign byte_acc  = i_frame_active & i_byte_valid;
  assign word_done = byte_acc &
                     ((BPW == 1) | ((state == S_COLLECT) && (byte_cnt == LAST_CNT)));
  assign o_busy    = (state == S_COLLECT);

  always_ff @(posedge i_clk_ILA or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      collect_q <= '0;
    end else if (!i_frame_active) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      collect_q <= '0;
    end else if (i_byte_valid) begin
      collect_q <= collect_d;
      case (state)
        S_IDLE: begin
          if (BPW > 1) begin
            byte_cnt <= CW'(1);
            state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (byte_cnt == LAST_CNT) begin
            byte_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            byte_cnt <= byte_cnt + CW'(1);
          end
        end
        default: begin
          byte_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // Padding bits above word_width in the last byte are simply not forwarded.
  word_hold_stage #(
    .width(word_width)
  ) u_hold (
    .i_clk_ILA     (i_clk_ILA),
    .i_rst_n       (i_rst_n),
    .i_load        (word_done),
    .i_data        (collect_d[word_width-1:0]),
    .i_frame_active(i_frame_active),
    .i_ready       (i_word_ready),
    .o_word        (o_word),
    .o_valid       (o_word_valid),
    .o_overflow    (o_overflow)
  );

endmodule

// File: tb/tb_byte_to_smp.sv
// Bench for byte_to_smp at widths 24, 12 and 8 sharing one input stream,
// checked every cycle against a byte-position model plus literal spot checks.
module tb_byte_to_smp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       frame;
  logic       bv;
  logic [7:0] byt;
  logic       rdy;

  logic [23:0] w24;
  logic [11:0] w12;
  logic [7:0]  w8;
  logic [2:0]  v_o;
  logic [2:0]  ovf_o;
  logic [2:0]  busy_o;
  logic [23:0] dut_word [3];

  byte_to_smp #(.word_width(24)) dut24 (
    .i_clk_ILA(clk), .i_rst_n(rst_n), .i_frame_active(frame), .i_byte_valid(bv),
    .i_byte(byt), .o_word(w24), .o_word_valid(v_o[0]), .i_word_ready(rdy),
    .o_overflow(ovf_o[0]), .o_busy(busy_o[0]));

  byte_to_smp #(.word_width(12)) dut12 (
    .i_clk_ILA(clk), .i_rst_n(rst_n), .i_frame_active(frame), .i_byte_valid(bv),
    .i_byte(byt), .o_word(w12), .o_word_valid(v_o[1]), .i_word_ready(rdy),
    .o_overflow(ovf_o[1]), .o_busy(busy_o[1]));

  byte_to_smp #(.word_width(8)) dut8 (
    .i_clk_ILA(clk), .i_rst_n(rst_n), .i_frame_active(frame), .i_byte_valid(bv),
    .i_byte(byt), .o_word(w8), .o_word_valid(v_o[2]), .i_word_ready(rdy),
    .o_overflow(ovf_o[2]), .o_busy(busy_o[2]));

  always_comb begin
    dut_word[0] = w24;
    dut_word[1] = {12'h000, w12};
    dut_word[2] = {16'h0000, w8};
  end

  // Reference model: bytes are placed by their position within the frame.
  int          widths [3] = '{24, 12, 8};
  int          m_cnt  [3] = '{0, 0, 0};
  logic [31:0] m_acc  [3] = '{0, 0, 0};
  logic [23:0] m_word [3] = '{0, 0, 0};
  bit          m_valid[3] = '{0, 0, 0};
  bit          m_ovf  [3] = '{0, 0, 0};
  int          bpw_m;
  logic [31:0] new_w;
  bit          done_m;
  bit          drop_m;

  int vectors = 0;
  int misses  = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_cnt[k] = 0; m_acc[k] = 0; m_word[k] = 0; m_valid[k] = 0; m_ovf[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        bpw_m  = (widths[k] - 1) / 8 + 1;
        done_m = 1'b0;
        drop_m = 1'b0;
        new_w  = 0;
        if (!frame) begin
          m_cnt[k] = 0;
          m_acc[k] = 0;
        end else if (bv) begin
          m_acc[k] = m_acc[k] | (32'(byt) << (8 * m_cnt[k]));
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] == bpw_m) begin
            done_m   = 1'b1;
            new_w    = m_acc[k] & ((32'h1 << widths[k]) - 32'h1);
            m_cnt[k] = 0;
            m_acc[k] = 0;
          end
        end
        if (done_m) begin
          if (!m_valid[k] || rdy) begin
            m_word[k]  = new_w[23:0];
            m_valid[k] = 1'b1;
          end else begin
            drop_m = 1'b1;
          end
        end else if (m_valid[k] && rdy) begin
          m_valid[k] = 1'b0;
        end
        if (drop_m) m_ovf[k] = 1'b1;
        else if (!frame) m_ovf[k] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("model_word[w%0d]", widths[k]), dut_word[k], m_word[k]);
        check($sformatf("model_valid[w%0d]", widths[k]), 24'(v_o[k]), 24'(m_valid[k]));
        check($sformatf("model_ovf[w%0d]", widths[k]), 24'(ovf_o[k]), 24'(m_ovf[k]));
        check($sformatf("model_busy[w%0d]", widths[k]), 24'(busy_o[k]), 24'(m_cnt[k] > 0));
      end
    end
  end

  task automatic drive(input logic f, input logic v, input logic [7:0] b, input logic r);
    @(posedge clk);
    #1;
    frame = f; bv = v; byt = b; rdy = r;
  endtask

  initial begin
    rst_n = 1'b0; frame = 1'b0; bv = 1'b0; byt = 8'h00; rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checking = 1'b1;
    check("reset_word", w24, 24'h0);
    check("reset_valid", 24'(v_o[0]), 24'h0);
    check("reset_ovf", 24'(ovf_o[0]), 24'h0);
    check("reset_busy", 24'(busy_o[0]), 24'h0);
    @(posedge clk); #1; rst_n = 1'b1;

    // 24-bit word, one-cycle valid with ready held high
    drive(1, 1, 8'h11, 1); drive(1, 1, 8'h22, 1); drive(1, 1, 8'h33, 1);
    drive(1, 0, 8'h00, 1);
    @(negedge clk);
    check("w24_word_332211", w24, 24'h332211);
    check("w24_valid_rise", 24'(v_o[0]), 24'h1);
    drive(0, 0, 8'h00, 1);
    @(negedge clk);
    check("w24_valid_one_cycle", 24'(v_o[0]), 24'h0);

    // 12-bit word, padding nibble discarded
    drive(1, 1, 8'hAB, 1); drive(1, 1, 8'hFC, 1); drive(1, 0, 8'h00, 1);
    @(negedge clk);
    check("w12_word_cab", {12'h0, w12}, 24'h000CAB);
    check("w12_valid", 24'(v_o[1]), 24'h1);
    drive(0, 0, 8'h00, 1);

    // partial word discarded by frame end
    drive(1, 1, 8'h01, 1); drive(1, 1, 8'h02, 1); drive(0, 0, 8'h00, 1);
    @(negedge clk);
    check("w24_busy_partial", 24'(busy_o[0]), 24'h1);
    drive(1, 1, 8'hA0, 1);
    @(negedge clk);
    check("w24_busy_after_frame_end", 24'(busy_o[0]), 24'h0);
    drive(1, 1, 8'hB0, 1); drive(1, 1, 8'hC0, 1); drive(1, 0, 8'h00, 1);
    @(negedge clk);
    check("w24_word_c0b0a0", w24, 24'hC0B0A0);
    check("w24_valid_c0b0a0", 24'(v_o[0]), 24'h1);

    // 8-bit overflow: second word dropped while first is held
    drive(1, 0, 8'h00, 1); drive(1, 1, 8'h5A, 0); drive(1, 1, 8'h6B, 0);
    drive(1, 0, 8'h00, 0);
    @(negedge clk);
    check("w8_held_5a", {16'h0, w8}, 24'h00005A);
    check("w8_ovf_set", 24'(ovf_o[2]), 24'h1);
    drive(1, 0, 8'h00, 1); drive(1, 0, 8'h00, 0);
    @(negedge clk);
    check("w8_valid_cleared", 24'(v_o[2]), 24'h0);
    check("w8_ovf_sticky", 24'(ovf_o[2]), 24'h1);
    drive(0, 0, 8'h00, 0); drive(1, 0, 8'h00, 0);
    @(negedge clk);
    check("w8_ovf_cleared", 24'(ovf_o[2]), 24'h0);

    // 8-bit: ready in the completion cycle replaces the word without overflow
    drive(1, 0, 8'h00, 1); drive(1, 1, 8'h70, 0); drive(1, 1, 8'h77, 1);
    drive(1, 0, 8'h00, 0);
    @(negedge clk);
    check("w8_word_77", {16'h0, w8}, 24'h000077);
    check("w8_valid_stays", 24'(v_o[2]), 24'h1);
    check("w8_no_ovf", 24'(ovf_o[2]), 24'h0);
    drive(1, 0, 8'h00, 1); drive(0, 0, 8'h00, 1);

    // asynchronous reset mid-word
    drive(1, 1, 8'h01, 1); drive(1, 1, 8'h02, 0);
    @(posedge clk); #1; rst_n = 1'b0; bv = 1'b0;
    @(negedge clk);
    check("rst_mid_word", w24, 24'h0);
    check("rst_mid_valid", 24'(v_o[0]), 24'h0);
    check("rst_mid_busy", 24'(busy_o[0]), 24'h0);
    check("rst_mid_ovf", 24'(ovf_o[0]), 24'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    drive(1, 1, 8'h10, 1); drive(1, 1, 8'h20, 1); drive(1, 1, 8'h30, 1);
    drive(1, 0, 8'h00, 1);
    @(negedge clk);
    check("w24_after_reset", w24, 24'h302010);
    check("w24_valid_after_reset", 24'(v_o[0]), 24'h1);
    drive(0, 0, 8'h00, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 15) != 0, $urandom_range(0, 1) != 0,
            8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
    end

    drive(0, 0, 8'h00, 1);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
